// File: rtl/match_judge_if.sv
// Port bundle between the game controller and its surroundings: button/cursor/colors in,
// phase code, picks and scoreboard out.
interface match_judge_if;
    logic        sel;
    logic [2:0]  cursor;
    logic [23:0] colors;
    logic [3:0]  step;
    logic [2:0]  secim1;
    logic [2:0]  secim2;
    logic [7:0]  matched;
    logic [7:0]  revealed;
    logic [2:0]  pairs;
    logic [7:0]  tries;
    logic        hit;
    logic        miss;
    logic        game_over;

    modport master (
        output sel, cursor, colors,
        input  step, secim1, secim2, matched, revealed, pairs, tries, hit, miss, game_over
    );

    modport slave (
        input  sel, cursor, colors,
        output step, secim1, secim2, matched, revealed, pairs, tries, hit, miss, game_over
    );
endinterface

// File: rtl/match_judge.sv
// Game-flow controller for the 8-square color matching game: records two picks, compares their
// hidden colors, keeps matches face-up, shows mismatches for SHOW_CYCLES, and flags game over.
module match_judge #(
    parameter int SHOW_CYCLES = 25_000_000
) (
    input logic          clk25MHz,
    input logic          rst,
    match_judge_if.slave bus
);

    typedef enum logic [2:0] {
        PICK1 = 3'd0,
        PICK2 = 3'd1,
        CHECK = 3'd2,
        SHOW  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int TW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_CYCLES - 1);

    state_t          state;
    state_t          state_n;
    logic            sel_q;
    logic            press;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_n;

    logic [2:0]      secim1_r, secim1_n;
    logic [2:0]      secim2_r, secim2_n;
    logic [7:0]      matched_r, matched_n;
    logic [7:0]      revealed_r, revealed_n;
    logic [2:0]      pairs_r, pairs_n;
    logic [7:0]      tries_r, tries_n;
    logic [3:0]      step_r, step_n;
    logic            hit_r, hit_n;
    logic            miss_r, miss_n;
    logic            game_over_r;

    logic            pick1_ok;
    logic            pick2_ok;
    logic            same_color;

    function automatic logic [2:0] color_of(input logic [23:0] colors, input logic [2:0] idx);
        logic [4:0] base;
        base = {2'b00, idx} + {1'b0, idx, 1'b0};
        return colors[base +: 3];
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [3:0] step_code(input state_t s);
        case (s)
            PICK1:       return 4'b0001;
            PICK2:       return 4'b0010;
            CHECK, SHOW: return 4'b0100;
            DONE:        return 4'b1000;
            default:     return 4'b0001;
        endcase
    endfunction

    // A press is a rising edge of the level button; sel_q resets high so a held button is not a press.
    assign press      = bus.sel & ~sel_q;
    assign pick1_ok   = press && !matched_r[bus.cursor];
    assign pick2_ok   = press && !matched_r[bus.cursor] && (bus.cursor != secim1_r);
    assign same_color = color_of(bus.colors, secim1_r) == color_of(bus.colors, secim2_r);

    always_ff @(posedge clk25MHz or posedge rst) begin
        if (rst) begin
            state       <= PICK1;
            sel_q       <= 1'b1;
            timer       <= '0;
            secim1_r    <= '0;
            secim2_r    <= '0;
            matched_r   <= '0;
            revealed_r  <= '0;
            pairs_r     <= '0;
            tries_r     <= '0;
            step_r      <= 4'b0001;
            hit_r       <= 1'b0;
            miss_r      <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            state       <= state_n;
            sel_q       <= bus.sel;
            timer       <= timer_n;
            secim1_r    <= secim1_n;
            secim2_r    <= secim2_n;
            matched_r   <= matched_n;
            revealed_r  <= revealed_n;
            pairs_r     <= pairs_n;
            tries_r     <= tries_n;
            step_r      <= step_n;
            hit_r       <= hit_n;
            miss_r      <= miss_n;
            game_over_r <= (state_n == DONE);
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            PICK1: if (pick1_ok) state_n = PICK2;
            PICK2: if (pick2_ok) state_n = CHECK;
            CHECK: begin
                if (!same_color)           state_n = SHOW;
                else if (pairs_r == 3'd3)  state_n = DONE;
                else                       state_n = PICK1;
            end
            SHOW:  if (timer == '0) state_n = PICK1;
            DONE:  if (press) state_n = PICK1;
            default: state_n = PICK1;
        endcase
    end

    always_comb begin
        secim1_n  = secim1_r;
        secim2_n  = secim2_r;
        matched_n = matched_r;
        pairs_n   = pairs_r;
        tries_n   = tries_r;
        timer_n   = timer;
        hit_n     = 1'b0;
        miss_n    = 1'b0;
        case (state)
            PICK1: if (pick1_ok) secim1_n = bus.cursor;
            PICK2: begin
                if (pick2_ok) begin
                    secim2_n = bus.cursor;
                    tries_n  = sat_inc8(tries_r);
                end
            end
            CHECK: begin
                if (same_color) begin
                    matched_n = matched_r | onehot8(secim1_r) | onehot8(secim2_r);
                    pairs_n   = pairs_r + 3'd1;
                    hit_n     = 1'b1;
                end else begin
                    miss_n  = 1'b1;
                    timer_n = SHOW_LOAD;
                end
            end
            SHOW: if (timer != '0) timer_n = timer - 1'b1;
            DONE: begin
                if (press) begin
                    matched_n = '0;
                    pairs_n   = '0;
                    tries_n   = '0;
                    secim1_n  = '0;
                    secim2_n  = '0;
                end
            end
            default: ;
        endcase

        // Display mask is computed from the upcoming state so it lands on the same edge as the picks.
        step_n     = step_code(state_n);
        revealed_n = matched_n;
        if (state_n == PICK2 || state_n == CHECK || state_n == SHOW)
            revealed_n = revealed_n | onehot8(secim1_n);
        if (state_n == CHECK || state_n == SHOW)
            revealed_n = revealed_n | onehot8(secim2_n);
    end

    assign bus.step      = step_r;
    assign bus.secim1    = secim1_r;
    assign bus.secim2    = secim2_r;
    assign bus.matched   = matched_r;
    assign bus.revealed  = revealed_r;
    assign bus.pairs     = pairs_r;
    assign bus.tries     = tries_r;
    assign bus.hit       = hit_r;
    assign bus.miss      = miss_r;
    assign bus.game_over = game_over_r;

endmodule

// File: tb/tb_match_judge.sv
// Bench for match_judge: directed game scenarios plus randomized play, judged by an abstract
// game model and a scoreboard of expected hit/miss outcomes.
module tb_match_judge;

    localparam int S = 4;

    logic clk25MHz = 1'b0;
    logic rst      = 1'b1;

    match_judge_if bus();

    match_judge #(.SHOW_CYCLES(S)) dut (
        .clk25MHz(clk25MHz),
        .rst(rst),
        .bus(bus)
    );

    always #20 clk25MHz = ~clk25MHz;

    typedef struct packed {
        logic       is_hit;
        logic [7:0] matched;
        logic [2:0] pairs;
        logic [7:0] tries;
        logic [3:0] step;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Abstract game model: phase 0 = choosing first square, 1 = choosing second, 3 = game won.
    int         m_phase;
    int         m_s1, m_s2, m_pairs, m_tries;
    logic [7:0] m_matched;
    logic [2:0] col [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [3:0] step_of(input int ph);
        case (ph)
            0:       return 4'b0001;
            1:       return 4'b0010;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_s1 = 0; m_s2 = 0; m_pairs = 0; m_tries = 0; m_matched = 8'h00;
    endtask

    task automatic load_colors();
        for (int i = 0; i < 8; i++) bus.colors[3*i +: 3] = col[i];
    endtask

    task automatic check_reset();
        chk("rst_step", bus.step, 4'b0001);
        chk("rst_secim1", bus.secim1, 0);
        chk("rst_secim2", bus.secim2, 0);
        chk("rst_matched", bus.matched, 0);
        chk("rst_revealed", bus.revealed, 0);
        chk("rst_pairs", bus.pairs, 0);
        chk("rst_tries", bus.tries, 0);
        chk("rst_hit", bus.hit, 0);
        chk("rst_miss", bus.miss, 0);
        chk("rst_game_over", bus.game_over, 0);
    endtask

    task automatic check_state(input logic pulse_ok);
        logic [7:0] rev;
        rev = m_matched | ((m_phase == 1) ? 8'(1 << m_s1) : 8'h00);
        chk("step", bus.step, step_of(m_phase));
        chk("secim1", bus.secim1, m_s1);
        chk("secim2", bus.secim2, m_s2);
        chk("matched", bus.matched, m_matched);
        chk("revealed", bus.revealed, rev);
        chk("pairs", bus.pairs, m_pairs);
        chk("tries", bus.tries, m_tries);
        chk("game_over", bus.game_over, (m_phase == 3) ? 1 : 0);
        if (!pulse_ok) chk("no_pulse", {bus.hit, bus.miss}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk25MHz);
        rst = 1'b1;
        bus.sel = 1'b0;
        load_colors();
        @(negedge clk25MHz);
        @(negedge clk25MHz);
        rst = 1'b0;
        model_reset();
    endtask

    // One press on square c. poke in 1..S raises sel again during SHOW; rst_at aborts SHOW with reset.
    task automatic press(input int c, input int poke, input int rst_at);
        logic       resolve;
        logic [7:0] rev;
        exp_t       e;
        resolve = 1'b0;
        @(negedge clk25MHz);
        bus.cursor = 3'(c);
        bus.sel    = 1'b1;
        @(negedge clk25MHz);
        bus.sel = 1'b0;
        case (m_phase)
            0: if (!m_matched[3'(c)]) begin m_s1 = c; m_phase = 1; end
            1: if (c != m_s1 && !m_matched[3'(c)]) begin
                m_s2 = c;
                if (m_tries < 255) m_tries++;
                resolve = 1'b1;
            end
            default: begin m_matched = 8'h00; m_pairs = 0; m_tries = 0; m_s1 = 0; m_s2 = 0; m_phase = 0; end
        endcase
        if (!resolve) begin
            check_state(1'b0);
            return;
        end
        rev = m_matched | 8'(1 << m_s1) | 8'(1 << m_s2);
        chk("check_step", bus.step, 4'b0100);
        chk("check_revealed", bus.revealed, rev);
        chk("check_tries", bus.tries, m_tries);
        chk("check_secim2", bus.secim2, m_s2);
        if (col[m_s1] == col[m_s2]) begin
            m_matched = rev;
            m_pairs++;
            m_phase = (m_pairs == 4) ? 3 : 0;
            e.is_hit = 1'b1; e.matched = m_matched; e.pairs = 3'(m_pairs);
            e.tries = 8'(m_tries); e.step = step_of(m_phase);
            sb_q.push_back(e);
            @(negedge clk25MHz);
            check_state(1'b1);
        end else begin
            e.is_hit = 1'b0; e.matched = m_matched; e.pairs = 3'(m_pairs);
            e.tries = 8'(m_tries); e.step = 4'b0100;
            sb_q.push_back(e);
            for (int k = 1; k <= S + 1; k++) begin
                bus.sel = (k - 1 == poke) ? 1'b1 : 1'b0;
                @(negedge clk25MHz);
                if (k == rst_at) begin
                    #1 rst = 1'b1;
                    #1 check_reset();
                    bus.sel = 1'b0;
                    @(negedge clk25MHz);
                    rst = 1'b0;
                    model_reset();
                    return;
                end
                if (k <= S) begin
                    chk("show_revealed", bus.revealed, rev);
                    chk("show_step", bus.step, 4'b0100);
                    if (k >= 2) chk("show_no_pulse", {bus.hit, bus.miss}, 0);
                end
            end
            bus.sel = 1'b0;
            m_phase = 0;
            check_state(1'b0);
        end
    endtask

    always @(negedge clk25MHz) begin : monitor
        exp_t e;
        if (!rst && (bus.hit || bus.miss)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse hit=%0b miss=%0b expected no outcome at %0t", bus.hit, bus.miss, $time);
            end else begin
                e = sb_q.pop_front();
                chk("sb_hit", bus.hit, e.is_hit);
                chk("sb_miss", bus.miss, !e.is_hit);
                chk("sb_matched", bus.matched, e.matched);
                chk("sb_pairs", bus.pairs, e.pairs);
                chk("sb_tries", bus.tries, e.tries);
                chk("sb_step", bus.step, e.step);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int poke;
        col[0] = 3'd1; col[5] = 3'd1; col[1] = 3'd2; col[2] = 3'd2;
        col[3] = 3'd3; col[7] = 3'd3; col[4] = 3'd4; col[6] = 3'd4;
        bus.sel = 1'b1;
        bus.cursor = 3'd0;
        bus.colors = 24'h0;
        load_colors();
        model_reset();

        // Button held high through and after reset must not count as a press.
        @(negedge clk25MHz);
        @(negedge clk25MHz);
        check_reset();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk25MHz);
            check_reset();
        end
        bus.sel = 1'b0;

        press(0, -1, -1); press(5, -1, -1);
        press(1, -1, -1); press(3, 1, -1);
        press(5, -1, -1);
        press(1, -1, -1); press(1, -1, -1); press(2, -1, -1);
        press(3, -1, -1); press(7, -1, -1);
        press(4, -1, -1); press(6, -1, -1);
        press(2, -1, -1);
        press(1, -1, -1); press(3, S, -1);
        press(0, -1, -1); press(4, -1, 2);

        // Every square a distinct color so every pair misses; drives tries to saturation.
        for (int i = 0; i < 8; i++) col[i] = 3'(i);
        do_reset();
        for (int i = 0; i < 258; i++) begin
            press(0, -1, -1);
            press(1, -1, -1);
        end
        chk("tries_saturated", bus.tries, 255);

        for (int round = 0; round < 2; round++) begin
            if (round == 0) begin
                for (int i = 0; i < 8; i++) col[i] = 3'($urandom_range(0, 7));
            end else begin
                for (int i = 0; i < 8; i++) col[i] = 3'(i / 2 + 1);
                for (int i = 7; i > 0; i--) begin
                    int j;
                    logic [2:0] t;
                    j = $urandom_range(0, i);
                    t = col[i]; col[i] = col[j]; col[j] = t;
                end
            end
            do_reset();
            for (int i = 0; i < 250; i++) begin
                poke = ($urandom_range(0, 3) == 0) ? $urandom_range(1, S) : -1;
                press($urandom_range(0, 7), poke, -1);
            end
        end

        @(negedge clk25MHz);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
